// File: rtl/imem_ctrl_pkg.sv
// Shared encodings and width helpers for the instruction-memory refill path.
// State codes are shared by imem_refill_ctrl and imem_pf_buffer.
package imem_ctrl_pkg;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_DONE     = 2'd2;
  localparam logic [1:0] S_PF_FETCH = 2'd3;

  // LINE_OFF_BITS: byte offset bits inside one line
  function automatic int line_off_bits(input int line_words);
    return $clog2(4 * line_words);
  endfunction

  function automatic int word_idx_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int wait_bits(input int mem_lat);
    return (mem_lat > 1) ? $clog2(mem_lat) : 1;
  endfunction

endpackage

// File: rtl/imem_pf_buffer.sv
// One-entry next-line prefetch buffer: valid, line tag, line data.
// Used by imem_refill_ctrl only when IMEM_PREFETCH_EN is defined.
module imem_pf_buffer
  import imem_ctrl_pkg::*;
#(
  parameter int TAG_W      = 10,
  parameter int LINE_WORDS = 4,
  parameter int WIW        = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [WIW-1:0]          wr_idx,
  input  logic [31:0]             wr_word,
  input  logic                    set_valid,
  input  logic [TAG_W-1:0]        set_tag,
  input  logic [TAG_W-1:0]        lk_tag,
  output logic                    hit,
  output logic [32*LINE_WORDS-1:0] rd_data
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid   <= 1'b0;
      tag     <= '0;
      rd_data <= '0;
    end else begin
      if (clear)
        valid <= 1'b0;
      if (wr_en)
        rd_data[32*int'(wr_idx) +: 32] <= wr_word;
      if (set_valid) begin
        valid <= 1'b1;
        tag   <= set_tag;
      end
    end
  end

  assign hit = valid && (tag == lk_tag);

endmodule

// File: rtl/imem_refill_ctrl.sv
// I-cache line refill sequencer for the single-port instruction memory.
// Optional next-line prefetch: define IMEM_PREFETCH_EN.
module imem_refill_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int TEXT_BITS  = 14,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [TEXT_BITS-1:0]      req_addr,
  output logic                      mem_ren,
  output logic [TEXT_BITS-3:0]      mem_addr,
  input  logic [31:0]               mem_dout,
  output logic                      fill_valid,
  output logic [TEXT_BITS-1:0]      fill_addr,
  output logic [32*LINE_WORDS-1:0]  fill_data,
  output logic                      busy
);

  localparam int OFF   = line_off_bits(LINE_WORDS);
  localparam int WIW   = word_idx_bits(LINE_WORDS);
  localparam int LAT_W = wait_bits(MEM_LAT);
  localparam int TAG_W = TEXT_BITS - OFF;

  logic [1:0]       state;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] cur_tag;
  logic [TAG_W-1:0] req_tag;
  logic [WIW-1:0]   wcnt;
  logic [LAT_W-1:0] lcnt;
  logic             last_wait;
  logic             last_word;
  logic             unused_off;

  assign req_tag    = req_addr[TEXT_BITS-1:OFF];
  assign unused_off = ^req_addr[OFF-1:0];
  assign last_wait  = (lcnt == LAT_W'(MEM_LAT - 1));
  assign last_word  = (wcnt == WIW'(LINE_WORDS - 1));

`ifdef IMEM_PREFETCH_EN
  logic [TAG_W-1:0]          pf_tag;
  logic                      pf_hit;
  logic                      pf_wr;
  logic [32*LINE_WORDS-1:0]  pf_data;

  assign pf_wr   = (state == S_PF_FETCH) && !req_valid && last_wait;
  assign cur_tag = (state == S_PF_FETCH) ? pf_tag : tag;

  imem_pf_buffer #(
    .TAG_W      (TAG_W),
    .LINE_WORDS (LINE_WORDS),
    .WIW        (WIW)
  ) u_pf (
    .clock     (clock),
    .reset     (reset),
    .clear     (state == S_DONE),
    .wr_en     (pf_wr),
    .wr_idx    (wcnt),
    .wr_word   (mem_dout),
    .set_valid (pf_wr && last_word),
    .set_tag   (pf_tag),
    .lk_tag    (req_tag),
    .hit       (pf_hit),
    .rd_data   (pf_data)
  );
`else
  assign cur_tag = tag;
`endif

  always_comb begin
    req_ready  = (state == S_IDLE);
    mem_ren    = (state == S_FETCH);
`ifdef IMEM_PREFETCH_EN
    req_ready  = req_ready || (state == S_PF_FETCH);
    mem_ren    = mem_ren || (state == S_PF_FETCH);
`endif
    fill_valid = (state == S_DONE);
    busy       = (state != S_IDLE);
    fill_addr  = {tag, {OFF{1'b0}}};
    // line base is aligned, so the word address is just tag:word
    mem_addr   = mem_ren ? {cur_tag, wcnt} : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      tag       <= '0;
      wcnt      <= '0;
      lcnt      <= '0;
      fill_data <= '0;
`ifdef IMEM_PREFETCH_EN
      pf_tag    <= '0;
`endif
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (req_valid) begin
            tag  <= req_tag;
            wcnt <= '0;
            lcnt <= '0;
`ifdef IMEM_PREFETCH_EN
            if (pf_hit) begin
              fill_data <= pf_data;
              state     <= S_DONE;
            end else begin
              state <= S_FETCH;
            end
`else
            state <= S_FETCH;
`endif
          end
        end
        (state == S_FETCH): begin
          if (last_wait) begin
            lcnt <= '0;
            wcnt <= wcnt + 1'b1;
            fill_data[32*int'(wcnt) +: 32] <= mem_dout;
            if (last_word)
              state <= S_DONE;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        (state == S_DONE): begin
`ifdef IMEM_PREFETCH_EN
          // tag + 1 wraps to line 0 at the top of text
          pf_tag <= tag + 1'b1;
          wcnt   <= '0;
          lcnt   <= '0;
          state  <= S_PF_FETCH;
`else
          state  <= S_IDLE;
`endif
        end
`ifdef IMEM_PREFETCH_EN
        (state == S_PF_FETCH): begin
          if (req_valid) begin
            tag   <= req_tag;
            wcnt  <= '0;
            lcnt  <= '0;
            state <= S_FETCH;
          end else if (last_wait) begin
            lcnt <= '0;
            wcnt <= wcnt + 1'b1;
            if (last_word)
              state <= S_IDLE;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_refill_ctrl.sv
// Scoreboard bench for imem_refill_ctrl with default parameters.
// Prefetch scenarios compile in with IMEM_PREFETCH_EN.
module tb_imem_refill_ctrl;

  localparam int TB = 14;
  localparam int LW = 4;
  localparam int ML = 2;
  localparam int LAT = LW * ML + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [TB-1:0] req_addr = '0;
  logic          mem_ren;
  logic [TB-3:0] mem_addr;
  logic [31:0]   mem_dout;
  logic          fill_valid;
  logic [TB-1:0] fill_addr;
  logic [32*LW-1:0] fill_data;
  logic          busy;

  typedef struct {
    logic [TB-1:0]    addr;
    logic [32*LW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;

  imem_refill_ctrl #(.TEXT_BITS(TB), .LINE_WORDS(LW), .MEM_LAT(ML)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [TB-3:0] a);
    return {4'hA, a, 4'h5, a};
  endfunction

  assign mem_dout = memf(mem_addr);

  function automatic logic [32*LW-1:0] line_of(input logic [TB-1:0] base);
    logic [32*LW-1:0] d;
    logic [TB-3:0]    w;
    d = '0;
    for (int k = 0; k < LW; k++) begin
      w = base[TB-1:2] + 12'(k);
      d[32*k +: 32] = memf(w);
    end
    return d;
  endfunction

  always @(posedge clock)
    if (reset && req_valid && req_ready) acc_cnt++;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // ends one negedge after the accepting edge, expected line queued
  task automatic issue(input logic [TB-1:0] a);
    int n;
    n = 0;
    req_addr = a;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept %h: req_ready=%b want 1", a, req_ready);
    end
    tick();
    req_valid = 1'b0;
    sb.push_back('{addr: a & 14'h3FF0, data: line_of(a & 14'h3FF0)});
  endtask

  task automatic wait_fill(input int start, input int lat, input string nm);
    int   n;
    exp_t e;
    n = start;
    while (fill_valid !== 1'b1 && n < lat + 20) begin
      tick();
      n++;
    end
    checks++;
    if (fill_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: fill_valid=%b want 1", nm, fill_valid);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s fill with empty scoreboard: fill_addr=%h want none",
               nm, fill_addr);
    end else begin
      e = sb.pop_front();
      checks += 3;
      if (n !== lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", nm, n, lat);
      end
      if (fill_addr !== e.addr) begin
        errors++;
        $display("FAIL %s fill_addr: got %h want %h", nm, fill_addr, e.addr);
      end
      if (fill_data !== e.data) begin
        errors++;
        $display("FAIL %s fill_data: got %h want %h", nm, fill_data, e.data);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    checks += 2;
    if (req_ready !== 1'b1 || mem_ren !== 1'b0) begin
      errors++;
      $display("FAIL in_reset ready/ren: got %b%b want 10", req_ready, mem_ren);
    end
    if (fill_data !== '0 || fill_addr !== '0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL in_reset data/addr: got %h %h %h want 0",
               fill_data, fill_addr, mem_addr);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({req_ready, mem_ren, fill_valid, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_idle: got %b want 1000",
               {req_ready, mem_ren, fill_valid, busy});
    end
  endtask

  task automatic test_miss();
    logic [TB-3:0] want;
    do_reset();
    issue(14'h0104);
    for (int i = 0; i < LW * ML; i++) begin
      want = 12'h040 + 12'(i / ML);
      checks++;
      if (mem_ren !== 1'b1 || mem_addr !== want || fill_valid !== 1'b0 ||
          req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL miss seq %0d: ren=%b addr=%h fv=%b rdy=%b busy=%b want 1 %h 0 0 1",
                 i, mem_ren, mem_addr, fill_valid, req_ready, busy, want);
      end
      tick();
    end
    wait_fill(LW * ML + 1, LAT, "miss");
    checks++;
    if (mem_ren !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: ren=%b rdy=%b want 0 0", mem_ren, req_ready);
    end
    tick();
    checks++;
    if (fill_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_done: fv=%b rdy=%b want 0 1", fill_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    do_reset();
    a0 = acc_cnt;
    req_addr = 14'h0200;
    req_valid = 1'b1;
    tick();
    req_addr = 14'h0300;
    sb.push_back('{addr: 14'h0200, data: line_of(14'h0200)});
    wait_fill(1, LAT, "b2b_first");
    checks++;
    if (acc_cnt - a0 !== 1) begin
      errors++;
      $display("FAIL b2b accepts during fill: got %0d want 1", acc_cnt - a0);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b ready after done: got %b want 1", req_ready);
    end
    sb.push_back('{addr: 14'h0300, data: line_of(14'h0300)});
    tick();
    req_valid = 1'b0;
    wait_fill(1, LAT, "b2b_second");
    checks++;
    if (acc_cnt - a0 !== 2) begin
      errors++;
      $display("FAIL b2b total accepts: got %0d want 2", acc_cnt - a0);
    end
  endtask

  task automatic test_last_line();
    do_reset();
    issue(14'h3FF8);
    wait_fill(1, LAT, "last_line");
`ifdef IMEM_PREFETCH_EN
    tick();
    checks++;
    if (mem_ren !== 1'b1 || mem_addr !== 12'h000) begin
      errors++;
      $display("FAIL pf_wrap: ren=%b addr=%h want 1 000", mem_ren, mem_addr);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int fv;
    do_reset();
    issue(14'h0200);
    tick();
    tick();
    #1;
    reset = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if (mem_ren !== 1'b0 || busy !== 1'b0 || fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort: ren=%b busy=%b fv=%b want 0 0 0",
               mem_ren, busy, fill_valid);
    end
    fv = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 2) reset = 1'b1;
      if (fill_valid === 1'b1) fv++;
    end
    checks++;
    if (fv !== 0) begin
      errors++;
      $display("FAIL abort fill pulses: got %0d want 0", fv);
    end
    issue(14'h0104);
    wait_fill(1, LAT, "after_abort");
  endtask

`ifdef IMEM_PREFETCH_EN
  task automatic test_prefetch();
    int n;
    do_reset();
    issue(14'h0100);
    wait_fill(1, LAT, "pf_demand");
    tick();
    checks++;
    if (mem_ren !== 1'b1 || mem_addr !== 12'h044 || busy !== 1'b1 ||
        req_ready !== 1'b1) begin
      errors++;
      $display("FAIL pf_start: ren=%b addr=%h busy=%b rdy=%b want 1 044 1 1",
               mem_ren, mem_addr, busy, req_ready);
    end
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL pf_finish: busy=%b want 0", busy);
    end
    issue(14'h0110);
    wait_fill(1, 1, "pf_hit");
    tick();
    checks++;
    if (mem_addr !== 12'h048 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pf_next: addr=%h busy=%b want 048 1", mem_addr, busy);
    end
    issue(14'h0200);
    wait_fill(1, LAT, "pf_abort");
  endtask
`endif

  initial begin
    test_reset();
    test_miss();
    test_back_to_back();
    test_last_line();
    test_reset_mid();
`ifdef IMEM_PREFETCH_EN
    test_prefetch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
